alu_share_sched: RTL and testbench
==================================

Name: alu_share_sched

Overview:
- Shares the single combinational KGPMini ALU between two requesters: requester 0 is the execute stage and requester 1 is the branch/address unit.
- Arbitrates round-robin and latches the winner's operands and control code.
- Drives the ALU for EXEC_CYCLES cycles, captures out/flags, and returns them on a valid/ready response channel to the granted requester only.

Parameters:
- DW, 32, operand/result width
- CW, 5, ALU control-code width
- FW, 3, ALU flag width
- EXEC_CYCLES, 1, cycles operands are held on the ALU before result capture (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accept
- req0_a, req0_b  in  DW  requester 0 operands
- req0_ctrl  in  CW  requester 0 ALU control
- req1_a, req1_b  in  DW  requester 1 operands
- req1_ctrl  in  CW  requester 1 ALU control
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_out  out  DW  captured ALU result (shared bus)
- rsp_flags  out  FW  captured ALU flags (shared bus)
- alu_a, alu_b  out  DW  to ALU operand inputs
- alu_ctrl  out  CW  to ALU control input
- alu_out  in  DW  from ALU result
- alu_flags  in  FW  from ALU flags
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- On `rst`:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - Counter=0; alu_a/alu_b/alu_ctrl regs=0; rsp_out/rsp_flags=0.
  - req_ready=0, rsp_valid=0, busy=0.
- Reset mid-operation discards the in-flight op; no response is issued.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant selection:
  - Grant g is chosen combinationally.
  - Only one req_valid bit set: grant that requester.
  - Both set: g = ~last_grant.
  - None set: stay IDLE, req_ready=0.
- IDLE, accept:
  - req_ready[g]=1 in IDLE only; req_ready[~g]=0 always.
  - Handshake = req_valid[g] & req_ready[g].
  - On handshake: latch the req_g operands/ctrl into the alu_* regs, last_grant<=g, counter<=0, go to EXEC.
- EXEC:
  - alu_* are held stable from the latched regs.
  - Counter increments each cycle.
  - On the cycle where counter==EXEC_CYCLES-1: rsp_out<=alu_out, rsp_flags<=alu_flags, go to RESP.
  - Default latency is request handshake edge -> rsp_valid high after 2 edges.
- RESP:
  - rsp_valid[g]=1, rsp_valid[~g]=0; rsp_out/rsp_flags are stable.
  - Wait indefinitely for rsp_ready[g]. On rsp_valid&rsp_ready go to IDLE; data is held until then.
  - rsp_ready of the non-granted requester is ignored.
- Throughput: max one op per EXEC_CYCLES+2 cycles. No new grant in EXEC/RESP; requests stay pending (requester holds valid and data).
- Starvation: requester held off by at most one op of the other while both are asserted.
- alu_* outputs keep their last values in IDLE/RESP (no glitching to 0).
- Widths: no arithmetic on data; counter width = $clog2(EXEC_CYCLES+1), minimum 1.

Decomposition:
- Package alu_sched_pkg:
  - State enum {IDLE, EXEC, RESP}.
  - Localparams DW/CW/FW defaults.
  - ALU op constants (ALU_ADD=5'b10000, others as the ALU defines).
- Sub-module rr_arb2:
  - Inputs: req[1:0], last_grant.
  - Output: gnt_idx, pure combinational.
  - Reusable for other shared KGPMini units.

Test Plan:
1. Single requester: req0 valid, A=512, B=512, ctrl=10000, rsp_ready[0]=1 -> rsp_valid[0] 2 edges after handshake, rsp_out=1024, rsp_valid[1] never high.
2. Simultaneous requests after reset: req0 (150+150) and req1 (1243+10) both valid -> req0 served first (out=300), then req1 (out=1253); third tie grants req0 again.
3. Response backpressure: rsp_ready[1]=0 for 5 cycles during a req1 op -> rsp_valid[1] and rsp_out held stable 5 cycles, req_ready stays 0, busy=1; release -> IDLE next edge.
4. EXEC_CYCLES=3 build: 512+1024 -> alu_a/b/ctrl stable for 3 EXEC cycles, rsp_out=1536 4 edges after handshake.
5. Reset mid-EXEC: assert rst in EXEC -> next edge state IDLE, busy=0, no rsp_valid, outputs 0; next request processes normally.
6. Sustained contention: both requesters valid continuously for 20 ops -> grants alternate 0,1,0,1 …, each requester gets exactly 10.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the KGPMini ALU sharing scheduler.
package alu_sched_pkg;

  localparam int ALU_DW = 32;
  localparam int ALU_CW = 5;
  localparam int ALU_FW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ALU_CW-1:0] ALU_AND = 5'b00000;
  localparam logic [ALU_CW-1:0] ALU_OR  = 5'b00001;
  localparam logic [ALU_CW-1:0] ALU_XOR = 5'b00010;
  localparam logic [ALU_CW-1:0] ALU_NOT = 5'b00011;
  localparam logic [ALU_CW-1:0] ALU_SLL = 5'b01000;
  localparam logic [ALU_CW-1:0] ALU_SRL = 5'b01001;
  localparam logic [ALU_CW-1:0] ALU_ADD = 5'b10000;
  localparam logic [ALU_CW-1:0] ALU_SUB = 5'b10001;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n + 1) > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; picks the requester that did not win last time on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = ~last_grant;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      default: gnt_idx = ~last_grant;
    endcase
  end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one combinational ALU between the execute stage (req 0) and the
// branch/address unit (req 1): arbitrate, hold operands, capture, respond.
module alu_share_sched
  import alu_sched_pkg::*;
#(
  parameter int DW          = ALU_DW,
  parameter int CW          = ALU_CW,
  parameter int FW          = ALU_FW,
  parameter int EXEC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [CW-1:0] req0_ctrl,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [CW-1:0] req1_ctrl,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_out,
  output logic [FW-1:0] rsp_flags,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [CW-1:0] alu_ctrl,
  input  logic [DW-1:0] alu_out,
  input  logic [FW-1:0] alu_flags,
  output logic          busy
);

  localparam int              CNTW     = cnt_w(EXEC_CYCLES);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(EXEC_CYCLES - 1);

  state_t              state, state_nxt;
  logic                last_grant;
  logic                gnt;
  logic [CNTW-1:0]     cnt;
  logic [1:0][DW-1:0]  op_a, op_b;
  logic [1:0][CW-1:0]  op_ctrl;
  logic                accept, exec_done, rsp_hs;

  assign op_a    = {req1_a,    req0_a};
  assign op_b    = {req1_b,    req0_b};
  assign op_ctrl = {req1_ctrl, req0_ctrl};

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt_idx    (gnt)
  );

  // last_grant doubles as the owner of the in-flight op once we leave IDLE.
  assign accept    = (state == IDLE) && req_valid[gnt];
  assign exec_done = (state == EXEC) && (cnt == CNT_LAST);
  assign rsp_hs    = (state == RESP) && rsp_ready[last_grant];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req_valid) req_ready = {gnt, ~gnt};
        if (accept) state_nxt = EXEC;
      end
      EXEC: if (exec_done) state_nxt = RESP;
      RESP: begin
        rsp_valid = {last_grant, ~last_grant};
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands stay registered outside EXEC so the shared unit never sees a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_out    <= '0;
      rsp_flags  <= '0;
    end else if (accept) begin
      last_grant <= gnt;
      cnt        <= '0;
      alu_a      <= op_a[gnt];
      alu_b      <= op_b[gnt];
      alu_ctrl   <= op_ctrl[gnt];
    end else if (state == EXEC) begin
      cnt <= cnt + CNTW'(1);
      if (exec_done) begin
        rsp_out   <= alu_out;
        rsp_flags <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench: transaction-level model checked every cycle, plus literal expectations per scenario.
module tb_alu_share_sched;
  import alu_sched_pkg::*;

  localparam int DW = 32;
  localparam int CW = 5;
  localparam int FW = 3;
  localparam int E  = 1;

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [CW-1:0] c; } op_t;
  typedef struct { int who; logic [DW-1:0] out; int lat; } rlog_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (EXEC_CYCLES=1)
  logic [1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [CW-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [DW-1:0] rsp_out, alu_a, alu_b, alu_out;
  logic [FW-1:0] rsp_flags, alu_flags;
  logic [CW-1:0] alu_ctrl;
  logic          busy;

  // second DUT (EXEC_CYCLES=3)
  logic [1:0]    v3 = '0, rdy3, rv3, rr3 = '0;
  logic [DW-1:0] a3in = '0, b3in = '0, zero_d = '0;
  logic [CW-1:0] c3in = '0, zero_c = '0;
  logic [DW-1:0] ro3, a3, b3, ao3;
  logic [FW-1:0] rf3, af3;
  logic [CW-1:0] c3;
  logic          busy3;

  function automatic logic [DW:0] alu_sum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [CW-1:0] c);
    case (c)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_SUB: return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction
  function automatic logic [FW-1:0] alu_flg(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
    logic [DW:0] s;
    s = alu_sum(a, b, c);
    return {s[DW], s[DW-1], s[DW-1:0] == '0};
  endfunction

  assign alu_out   = alu_sum(alu_a, alu_b, alu_ctrl)[DW-1:0];
  assign alu_flags = alu_flg(alu_a, alu_b, alu_ctrl);
  assign ao3       = alu_sum(a3, b3, c3)[DW-1:0];
  assign af3       = alu_flg(a3, b3, c3);

  alu_share_sched #(.DW(DW), .CW(CW), .FW(FW), .EXEC_CYCLES(E)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .alu_flags(alu_flags), .busy(busy)
  );

  alu_share_sched #(.DW(DW), .CW(CW), .FW(FW), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
    .req0_a(a3in), .req0_b(b3in), .req0_ctrl(c3in),
    .req1_a(zero_d), .req1_b(zero_d), .req1_ctrl(zero_c),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_out(ro3), .rsp_flags(rf3),
    .alu_a(a3), .alu_b(b3), .alu_ctrl(c3), .alu_out(ao3),
    .alu_flags(af3), .busy(busy3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    op_t o;
    o.a = a; o.b = b; o.c = c;
    return o;
  endfunction

  // requester drivers: hold valid+data until accepted
  op_t q0[$], q1[$];
  int  pops0 = 0, pops1 = 0;
  logic [1:0] drv_hs;
  always begin
    @(negedge clk);
    drv_hs = rst ? 2'b00 : (req_valid & req_ready);
    @(posedge clk);
    #1;
    if (drv_hs[0] && q0.size() != 0) begin void'(q0.pop_front()); pops0++; end
    if (drv_hs[1] && q1.size() != 0) begin void'(q1.pop_front()); pops1++; end
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_ctrl = q0[0].c; end
    if (q1.size() != 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_ctrl = q1[0].c; end
  end

  // transaction model: owner (-1 = free), age = cycles since accept
  int            m_own = -1, m_age = 0, m_last = 1, eg;
  logic [DW-1:0] m_a = '0, m_b = '0, m_out = '0;
  logic [CW-1:0] m_c = '0;
  logic [FW-1:0] m_flg = '0;
  logic [1:0]    e_rdy, e_vld;
  bit            armed = 0;
  int            cyc_n = 0, v1_cnt = 0;
  int            acc_cyc [2];
  rlog_t         rlog[$];
  rlog_t         ent;

  always @(negedge clk) begin
    cyc_n++;
    if (armed) begin
      eg = (req_valid == 2'b01) ? 0 : (req_valid == 2'b10) ? 1 : 1 - m_last;
      e_rdy = (m_own < 0 && req_valid != 2'b00) ? 2'(1 << eg) : 2'b00;
      e_vld = (m_own >= 0 && m_age >= E) ? 2'(1 << m_own) : 2'b00;
      chk("busy", 64'(busy), 64'(m_own >= 0));
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_vld));
      chk("rsp_out", 64'(rsp_out), 64'(m_out));
      chk("rsp_flags", 64'(rsp_flags), 64'(m_flg));
      chk("alu_a", 64'(alu_a), 64'(m_a));
      chk("alu_b", 64'(alu_b), 64'(m_b));
      chk("alu_ctrl", 64'(alu_ctrl), 64'(m_c));
      for (int r = 0; r < 2; r++) begin
        if (rsp_valid[r] && rsp_ready[r]) begin
          ent.who = r; ent.out = rsp_out; ent.lat = cyc_n - acc_cyc[r];
          rlog.push_back(ent);
        end
        if (!rst && req_valid[r] && req_ready[r]) acc_cyc[r] = cyc_n;
      end
      if (rsp_valid[1]) v1_cnt++;
    end
    if (rst) begin
      m_own = -1; m_age = 0; m_last = 1;
      m_a = '0; m_b = '0; m_c = '0; m_out = '0; m_flg = '0;
      armed = 1;
    end else if (armed) begin
      if (m_own < 0) begin
        if (req_valid != 2'b00) begin
          m_own = eg; m_last = eg; m_age = 0;
          m_a = eg ? req1_a : req0_a;
          m_b = eg ? req1_b : req0_b;
          m_c = eg ? req1_ctrl : req0_ctrl;
        end
      end else if (m_age < E) begin
        if (m_age == E - 1) begin
          m_out = alu_sum(m_a, m_b, m_c)[DW-1:0];
          m_flg = alu_flg(m_a, m_b, m_c);
        end
        m_age++;
      end else if (rsp_ready[m_own]) begin
        m_own = -1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req_valid != 2'b00 || busy) && n < bound) begin
      cyc(1);
      n++;
    end
    chk(nm, 64'(n < bound), 64'd1);
  endtask

  task automatic chk_ent(input string nm, input int idx, input int who, input logic [DW-1:0] out);
    chk({nm, "_present"}, 64'(idx < rlog.size()), 64'd1);
    if (idx < rlog.size()) begin
      chk({nm, "_who"}, 64'(rlog[idx].who), 64'(who));
      chk({nm, "_out"}, 64'(rlog[idx].out), 64'(out));
    end
  endtask

  initial begin
    int base, v1b, p, n, c0, c1;
    // reset state
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rdy", 64'(req_ready), 0);
    chk("rst_vld", 64'(rsp_valid), 0);
    chk("rst_out", 64'(rsp_out), 0);
    chk("rst_alu_a", 64'(alu_a), 0);
    cyc(1);

    // 1: single requester, ADD 512+512
    rsp_ready = 2'b11;
    base = rlog.size(); v1b = v1_cnt;
    q0.push_back(mk(512, 512, ALU_ADD));
    wait_idle("t1_done", 40);
    chk("t1_count", 64'(rlog.size() - base), 1);
    chk_ent("t1", base, 0, 1024);
    if (rlog.size() > base) chk("t1_latency", 64'(rlog[base].lat), 2);
    chk("t1_no_v1", 64'(v1_cnt - v1b), 0);

    // 2: simultaneous requests after reset, then a third tie
    rst = 1'b1; cyc(1); rst = 1'b0;
    base = rlog.size();
    q0.push_back(mk(150, 150, ALU_ADD));
    q1.push_back(mk(1243, 10, ALU_ADD));
    wait_idle("t2a_done", 40);
    q0.push_back(mk(1, 1, ALU_ADD));
    q1.push_back(mk(2, 2, ALU_ADD));
    wait_idle("t2b_done", 40);
    chk_ent("t2_first", base, 0, 300);
    chk_ent("t2_second", base + 1, 1, 1253);
    chk_ent("t2_third", base + 2, 0, 2);
    chk_ent("t2_fourth", base + 3, 1, 4);

    // 3: response backpressure on requester 1
    rsp_ready = 2'b01;
    base = rlog.size();
    q1.push_back(mk(7, 8, ALU_ADD));
    n = 0;
    while (rsp_valid != 2'b10 && n < 20) begin cyc(1); n++; end
    chk("t3_reach", 64'(rsp_valid), 64'(2'b10));
    q0.push_back(mk(3, 4, ALU_ADD));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_vld", 64'(rsp_valid), 64'(2'b10));
      chk("t3_hold_out", 64'(rsp_out), 15);
      chk("t3_hold_rdy", 64'(req_ready), 0);
      chk("t3_hold_busy", 64'(busy), 1);
    end
    @(posedge clk); #3;
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t3_rel_busy", 64'(busy), 0);
    chk("t3_rel_vld", 64'(rsp_valid), 0);
    chk("t3_rel_rdy", 64'(req_ready), 64'(2'b01));
    cyc(1);
    wait_idle("t3_done", 40);
    chk_ent("t3_r1", base, 1, 15);
    chk_ent("t3_r0", base + 1, 0, 7);

    // 5: reset while in EXEC
    base = rlog.size(); p = pops0;
    q0.push_back(mk(5, 6, ALU_ADD));
    n = 0;
    while (pops0 == p && n < 20) begin cyc(1); n++; end
    chk("t5_in_exec", 64'(busy), 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_vld", 64'(rsp_valid), 0);
    chk("t5_out", 64'(rsp_out), 0);
    chk("t5_alu_a", 64'(alu_a), 0);
    chk("t5_alu_b", 64'(alu_b), 0);
    cyc(1);
    chk("t5_no_rsp", 64'(rlog.size() - base), 0);
    q1.push_back(mk(100, 23, ALU_ADD));
    wait_idle("t5_done", 40);
    chk_ent("t5_after", base, 1, 123);

    // 6: sustained contention, 10 ops each
    base = rlog.size();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(mk(i, 2 * i, ALU_ADD));
      q1.push_back(mk(1000 + i, i, ALU_ADD));
    end
    wait_idle("t6_done", 200);
    chk("t6_count", 64'(rlog.size() - base), 20);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 20 && base + k < rlog.size(); k++) begin
      chk("t6_who", 64'(rlog[base + k].who), 64'(k % 2));
      chk("t6_out", 64'(rlog[base + k].out), (k % 2 == 0) ? 64'(3 * (k / 2)) : 64'(1000 + 2 * (k / 2)));
      if (rlog[base + k].who == 0) c0++; else c1++;
    end
    chk("t6_n0", 64'(c0), 10);
    chk("t6_n1", 64'(c1), 10);

    // 4: EXEC_CYCLES=3 instance, 512+1024
    a3in = 512; b3in = 1024; c3in = ALU_ADD; rr3 = 2'b11; v3 = 2'b01;
    @(negedge clk);
    chk("t4_accept", 64'(rdy3), 64'(2'b01));
    @(posedge clk); #1;
    v3 = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t4_alu_a", 64'(a3), 512);
      chk("t4_alu_b", 64'(b3), 1024);
      chk("t4_alu_ctrl", 64'(c3), 64'(ALU_ADD));
      chk("t4_no_vld", 64'(rv3), 0);
      chk("t4_busy", 64'(busy3), 1);
    end
    @(negedge clk);
    chk("t4_vld", 64'(rv3), 64'(2'b01));
    chk("t4_out", 64'(ro3), 1536);
    @(negedge clk);
    chk("t4_idle", 64'(busy3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
